// File: rtl/uart_rx_fifo_if.sv
// Core-facing read/status port of the UART receive FIFO.
// The core is the master: it pops bytes and clears the sticky error flags.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd;
    logic          clr_err;
    logic [7:0]    dout;
    logic          empty;
    logic [CW-1:0] count;
    logic          overrun;
    logic          framing_err;
    logic          rts;

    modport master (
        output rd, clr_err,
        input  dout, empty, count, overrun, framing_err, rts
    );

    modport slave (
        input  rd, clr_err,
        output dout, empty, count, overrun, framing_err, rts
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (9600/300 baud, 16x oversampled) feeding a show-ahead FIFO,
// with sticky overrun/framing flags and RTS hysteresis on the fill level.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_HI     = 12,
    parameter int RTS_LO     = 8
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          baud_rate,
    input  logic          rxd,
    uart_rx_fifo_if.slave bus
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int DIV_FAST = (CLK_HZ + 9600 * 8) / (9600 * 16);
    localparam int DIV_SLOW = (CLK_HZ + 300 * 8) / (300 * 16);
    localparam int DW       = $clog2(DIV_SLOW + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rx_meta;
    logic          rxs;
    logic          baud_q;
    logic          baud_chg;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_max;
    logic          div_clr;
    logic          tick;

    state_t        state, state_nxt;
    logic [3:0]    smp_cnt, smp_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic          push;
    logic          ferr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] fill;
    logic          empty_i;
    logic          full;
    logic          do_wr;
    logic          do_rd;
    logic          overrun_q;
    logic          ferr_q;
    logic          rts_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            baud_q  <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            baud_q  <= baud_rate;
        end
    end

    assign baud_chg = (baud_rate != baud_q);
    assign div_max  = baud_rate ? DW'(DIV_SLOW - 1) : DW'(DIV_FAST - 1);
    assign tick     = (div_cnt == div_max);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            div_cnt <= '0;
        else if (div_clr || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            smp_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            smp_cnt <= smp_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        smp_nxt   = smp_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
        div_clr   = 1'b0;
        if (baud_chg) begin
            state_nxt = IDLE;
            smp_nxt   = '0;
            bit_nxt   = '0;
            div_clr   = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt = START;
                        smp_nxt   = '0;
                        div_clr   = 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp_cnt == 4'd7) begin
                            smp_nxt   = '0;
                            bit_nxt   = '0;
                            state_nxt = rxs ? IDLE : DATA;
                        end else begin
                            smp_nxt = smp_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    // The 4-bit sample counter wraps 15 -> 0 exactly at each mid-bit sample.
                    if (tick) begin
                        smp_nxt = smp_cnt + 4'd1;
                        if (smp_cnt == 4'd15) begin
                            sh_nxt  = {rxs, shreg[7:1]};
                            bit_nxt = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state_nxt = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        smp_nxt = smp_cnt + 4'd1;
                        if (smp_cnt == 4'd15) begin
                            push      = rxs;
                            ferr_set  = !rxs;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign fill    = wr_ptr - rd_ptr;
    assign empty_i = (wr_ptr == rd_ptr);
    assign full    = (fill == CW'(FIFO_DEPTH));
    assign do_rd   = bus.rd && !empty_i;
    assign do_wr   = push && (!full || bus.rd);

    // NOTE: the storage array has no reset; pointers alone define validity and dout is masked when empty.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Error set takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (push && full && !bus.rd)
                overrun_q <= 1'b1;
            else if (bus.clr_err)
                overrun_q <= 1'b0;
            if (ferr_set)
                ferr_q <= 1'b1;
            else if (bus.clr_err)
                ferr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            rts_q <= 1'b0;
        else if (fill >= CW'(RTS_HI))
            rts_q <= 1'b1;
        else if (fill <= CW'(RTS_LO))
            rts_q <= 1'b0;
    end

    assign bus.dout        = empty_i ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign bus.empty       = empty_i;
    assign bus.count       = fill;
    assign bus.overrun     = overrun_q;
    assign bus.framing_err = ferr_q;
    assign bus.rts         = rts_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front-end for the UK101 core's ACIA path. It takes the raw UART_RXD line, deserialises 8N1 frames at a selectable 9600 or 300 baud, and buffers the bytes in a small FIFO for the core to read. It drives the RTS flow-control output from FIFO fill level. It sits between the top-level UART pins and the uk101 instance, in the clk_sys (50 MHz) domain.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
FIFO_DEPTH, 16, FIFO entries; must be a power of 2.
RTS_HI, 12, fill count at or above which rts asserts.
RTS_LO, 8, fill count at or below which rts deasserts; must be less than RTS_HI.

Ports:
clk  in  1  system clock (clk_sys).
n_reset  in  1  asynchronous active-low reset.
baud_rate  in  1  0 = 9600 baud, 1 = 300 baud (status[7]).
rxd  in  1  asynchronous serial input; idles high.
rd  in  1  pop strobe, one byte per cycle high.
dout  out  8  FIFO head byte; valid when empty = 0.
empty  out  1  FIFO empty.
count  out  log2(FIFO_DEPTH)+1  current fill level.
overrun  out  1  sticky: a byte was dropped because the FIFO was full.
framing_err  out  1  sticky: a stop bit was sampled low.
clr_err  in  1  clears overrun and framing_err.
rts  out  1  1 = stop sending (buffer near full); 0 = ready.

Behaviour:
- Reset values (async, while n_reset = 0):
  - rxd synchroniser = 1, FSM = IDLE, all counters = 0.
  - FIFO pointers = 0, so empty = 1 and count = 0.
  - overrun = 0, framing_err = 0, rts = 0, dout = 0.
- Reset asserted mid-frame aborts the frame and discards FIFO contents.
- Oversample tick: 16x the baud rate.
  - Divisor = round(CLK_HZ / (baud × 16)), giving 326 at 9600 and 10417 at 300 with the default CLK_HZ.
  - The divider counts 0..divisor-1 and pulses tick for one clk on wrap.
- rxd passes through a 2-flop synchroniser. All decisions use the synchronised value, rxs.
- FSM states: IDLE, START, DATA, STOP. The sample counter is 4 bits; the bit counter is 3 bits.
  - IDLE: rxs = 0 → START. Clear the sample counter and restart the tick divider so phase aligns to the edge.
  - START: on the tick where the sample counter reaches 7 (mid start bit):
    - rxs = 0 → DATA, sample counter cleared.
    - rxs = 1 → IDLE (glitch reject).
  - DATA: every 16th tick after that point (mid bit), shift rxs into bit 7 of the shift register (LSB first). After 8 bits → STOP.
  - STOP: at mid stop bit:
    - rxs = 1 → push the byte.
    - rxs = 0 → set framing_err and discard the byte.
    - Either way → IDLE. A new start bit may be detected from the next clk.
- Any change of baud_rate: FSM → IDLE, divider cleared, the partial frame is discarded. The FIFO is untouched.
- Push latency: the byte is visible at dout/count 1 clk after the mid-stop sample cycle.
- FIFO: show-ahead. dout = mem[rd_ptr]. Pointers are 1 bit wider than the address to distinguish full from empty.
  - rd with empty = 1 is ignored. The pointer is not moved and no error is raised.
  - Push with full and no rd: the byte is dropped and overrun is set.
  - Push with full and rd in the same cycle: both are accepted and count is unchanged.
  - Push with empty and rd in the same cycle: rd is ignored, the push is accepted, and count = 1.
- overrun and framing_err stay set until clr_err = 1. A clr_err and a new error event in the same cycle leave the flag set (set wins).
- rts is registered with hysteresis:
  - Set when count ≥ RTS_HI.
  - Cleared when count ≤ RTS_LO.
  - Otherwise holds its value.

Test Plan:
- 9600 baud, send 0x55 (8N1, 5208 clk/bit) → empty falls 1 clk after mid stop; dout = 0x55, count = 1. rd → empty = 1, count = 0.
- 9600 baud, 250 ns low pulse on rxd → FSM returns to IDLE, no push, no error flags.
- 9600 baud, send 0xA3 with stop bit low → framing_err = 1, count = 0. clr_err → framing_err = 0.
- 9600 baud, send 17 bytes 0x00..0x10 with no rd:
  - rts = 1 after the 12th push.
  - Count saturates at 16; overrun = 1 after the 17th.
  - Draining gives 0x00..0x0F in order; rts = 0 once count = 8.
- FIFO full, rd pulsed in the same cycle as a push of 0x7E → count stays 16, overrun stays 0, 0x7E is last out.
- 300 baud, send 0xC9 → received correctly. Toggle baud_rate mid-frame → no push; the next full frame is received correctly.
